// File: rtl/block_array_ctrl.sv
// -----------------------------------------------------------------------------
// block_array_ctrl
//   Owns the ROWS x COLS block playfield. A single write FSM commits row writes
//   only during vertical blanking, runs a one-row-per-cycle clear sweep on
//   request, serves a registered single-bit pixel read port, and generates the
//   level-dependent game update tick from the slow divider taps.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   reset        asynchronous, active-high reset
//   vblank       high during vertical blanking (the only time rows are written)
//   wr_req       level request to write one row
//   wr_row       target row of the write
//   wr_data      row contents, bit c is column c
//   wr_ack       one-cycle pulse, the cycle after the row was written
//   clr_req      level request to clear the whole array
//   clr_busy     high while the clear sweep runs
//   rd_row       pixel-pipeline read row
//   rd_col       pixel-pipeline read column
//   rd_pixel     registered array bit at (rd_row, rd_col), 1-cycle latency
//   level        game level, higher gives a faster tick
//   div_tap      free-running divider bits compared against the threshold
//   update_tick  one-cycle pulse that advances the game FSM
// -----------------------------------------------------------------------------
module block_array_ctrl #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int THRES_BASE = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    vblank,
  input  logic                    wr_req,
  input  logic [$clog2(ROWS)-1:0] wr_row,
  input  logic [COLS-1:0]         wr_data,
  output logic                    wr_ack,
  input  logic                    clr_req,
  output logic                    clr_busy,
  input  logic [$clog2(ROWS)-1:0] rd_row,
  input  logic [$clog2(COLS)-1:0] rd_col,
  output logic                    rd_pixel,
  input  logic [2:0]              level,
  input  logic [3:0]              div_tap,
  output logic                    update_tick
);

  localparam int ROW_W = $clog2(ROWS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VB = 2'd1,
    WRITE   = 2'd2,
    CLEAR   = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic              latch_en;
  logic [ROW_W-1:0]  lat_row;
  logic [COLS-1:0]   lat_data;
  logic [ROW_W-1:0]  clr_cnt;
  logic [COLS-1:0]   arr [ROWS];

  logic [3:0]        thres;
  logic              match;
  logic              armed;

  // ---------------------------------------------------------------------------
  // Write FSM: next state
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through the
  // case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    latch_en  = 1'b0;
    unique case (state)
      IDLE: begin
        // Clear wins over write; a write is refused during the ack cycle so a
        // request held high through the ack is not committed twice.
        if (clr_req) begin
          state_nxt = CLEAR;
        end else if (wr_req && !wr_ack) begin
          latch_en  = 1'b1;
          state_nxt = WAIT_VB;
        end
      end
      WAIT_VB: if (vblank) state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      CLEAR:   if (clr_cnt == ROW_W'(ROWS - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write FSM: state, latched request, clear counter, ack
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      lat_row  <= '0;
      lat_data <= '0;
      clr_cnt  <= '0;
      wr_ack   <= 1'b0;
    end else begin
      state  <= state_nxt;
      wr_ack <= (state == WRITE);
      if (latch_en) begin
        lat_row  <= wr_row;
        lat_data <= wr_data;
      end
      // Counter runs only in CLEAR and wraps to 0 after the last row, so each
      // sweep starts from row 0.
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
      else                clr_cnt <= '0;
    end
  end

  assign clr_busy = (state == CLEAR);

  // ---------------------------------------------------------------------------
  // Storage array and read port
  // ---------------------------------------------------------------------------
  // NOTE: the array is deliberately reset: a write aborted by reset must leave
  // an all-zero playfield, so this storage is flops rather than a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++) arr[r] <= '0;
      rd_pixel <= 1'b0;
    end else begin
      // The read samples the array before this edge's write lands, so a read
      // of the row being written returns the old contents.
      rd_pixel <= arr[rd_row][rd_col];
      if (state == WRITE) arr[lat_row] <= lat_data;
      else if (state == CLEAR) arr[clr_cnt] <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Update tick
  // ---------------------------------------------------------------------------
  assign thres = 4'(THRES_BASE) - {1'b0, level};
  assign match = (div_tap == thres);

  // armed records "the previous cycle did not match", so only the first cycle
  // of a match window can tick. A match during a clear still disarms, which
  // drops the tick instead of deferring it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) armed <= 1'b1;
    else       armed <= !match;
  end

  assign update_tick = match && armed && !clr_busy && !reset;

endmodule
